// File: rtl/jesd204b_link_seq.sv
// Bring-up / recovery sequencer for one JESD204B link (TX+RX) with PLL-lock filter and retries.
// Optional loss-of-sync debounce in UP: define JESD_SEQ_LOSS_DEBOUNCE_EN.
module jesd204b_link_seq #(
   parameter int LOCK_FILT    = 16,
   parameter int RST_CYCLES   = 32,
   parameter int SYNC_TIMEOUT = 4096,
   parameter int MAX_RETRY    = 3
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
   ,
   parameter int DEBOUNCE     = 4
`endif
) (
   input  logic       link_clk,
   input  logic       reset_b,
   input  logic       start,
   input  logic       pll_lock,
   input  logic       tx_sync_n,
   input  logic       rx_sync_n,
   output logic       tx_en,
   output logic       rx_en,
   output logic       core_reset_b,
   output logic       link_up,
   output logic       link_fail,
   output logic [2:0] state,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      RESET     = 3'd2,
      WAIT_SYNC = 3'd3,
      UP        = 3'd4,
      FAIL      = 3'd5
   } state_t;

   localparam int LW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int TW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILT - 1);
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(SYNC_TIMEOUT - 1);
   localparam int MR = (MAX_RETRY > 15) ? 15 : MAX_RETRY;
   localparam logic [3:0] MAX_R = 4'(MR);

   logic lock_s1_q, lock_s2_q;
   logic tx_s1_q, tx_s2_q;
   logic rx_s1_q, rx_s2_q;

   state_t        state_q, state_d;
   logic [3:0]    retry_q, retry_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tx_en_q, rx_en_q, core_reset_b_q, link_up_q, link_fail_q;
   logic          en_d, core_reset_b_d, link_up_d, link_fail_d;
   logic          retry_go, sync_ok;

`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
`endif

   assign sync_ok = tx_s2_q & rx_s2_q;

   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      lock_cnt_d = '0;
      rst_cnt_d  = '0;
      tmo_cnt_d  = '0;
      retry_go   = 1'b0;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
      deb_cnt_d  = '0;
`endif
      // counters only advance while staying put, so every transition clears them
      case (state_q)
         IDLE: begin
            if (start) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s2_q) begin
               if (lock_cnt_q == LOCK_LAST) state_d = RESET;
               else lock_cnt_d = lock_cnt_q + LW'(1);
            end
         end
         RESET: begin
            if (rst_cnt_q == RST_LAST) state_d = WAIT_SYNC;
            else rst_cnt_d = rst_cnt_q + RW'(1);
         end
         WAIT_SYNC: begin
            if (sync_ok) state_d = UP;
            else if (tmo_cnt_q == TMO_LAST) retry_go = 1'b1;
            else tmo_cnt_d = tmo_cnt_q + TW'(1);
         end
         UP: begin
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
            if (!sync_ok) begin
               if (deb_cnt_q == DEB_LAST) retry_go = 1'b1;
               else deb_cnt_d = deb_cnt_q + DW'(1);
            end
`else
            if (!sync_ok) retry_go = 1'b1;
`endif
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: state_d = IDLE;
      endcase

      if (retry_go) begin
         if (retry_q < MAX_R) begin
            retry_d = retry_q + 4'd1;
            state_d = RESET;
         end else begin
            state_d = FAIL;
         end
      end

      // lock loss restarts the filter without spending a retry
      if (!lock_s2_q &&
          (state_q == RESET || state_q == WAIT_SYNC || state_q == UP)) begin
         state_d    = WAIT_LOCK;
         retry_d    = retry_q;
         lock_cnt_d = '0;
         rst_cnt_d  = '0;
         tmo_cnt_d  = '0;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
         deb_cnt_d  = '0;
`endif
      end

      if (!start) begin
         state_d    = IDLE;
         lock_cnt_d = '0;
         rst_cnt_d  = '0;
         tmo_cnt_d  = '0;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
         deb_cnt_d  = '0;
`endif
      end

      if (state_d == IDLE) retry_d = '0;

      en_d = (state_d == RESET) || (state_d == WAIT_SYNC) || (state_d == UP);
      core_reset_b_d = (state_d == WAIT_SYNC) || (state_d == UP);
      link_up_d   = (state_d == UP);
      link_fail_d = (state_d == FAIL);
   end

   always_ff @(posedge link_clk or negedge reset_b) begin
      if (!reset_b) begin
         lock_s1_q      <= 1'b0;
         lock_s2_q      <= 1'b0;
         tx_s1_q        <= 1'b0;
         tx_s2_q        <= 1'b0;
         rx_s1_q        <= 1'b0;
         rx_s2_q        <= 1'b0;
         state_q        <= IDLE;
         retry_q        <= '0;
         lock_cnt_q     <= '0;
         rst_cnt_q      <= '0;
         tmo_cnt_q      <= '0;
         tx_en_q        <= 1'b0;
         rx_en_q        <= 1'b0;
         core_reset_b_q <= 1'b0;
         link_up_q      <= 1'b0;
         link_fail_q    <= 1'b0;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
         deb_cnt_q      <= '0;
`endif
      end else begin
         lock_s1_q      <= pll_lock;
         lock_s2_q      <= lock_s1_q;
         tx_s1_q        <= tx_sync_n;
         tx_s2_q        <= tx_s1_q;
         rx_s1_q        <= rx_sync_n;
         rx_s2_q        <= rx_s1_q;
         state_q        <= state_d;
         retry_q        <= retry_d;
         lock_cnt_q     <= lock_cnt_d;
         rst_cnt_q      <= rst_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         tx_en_q        <= en_d;
         rx_en_q        <= en_d;
         core_reset_b_q <= core_reset_b_d;
         link_up_q      <= link_up_d;
         link_fail_q    <= link_fail_d;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
         deb_cnt_q      <= deb_cnt_d;
`endif
      end
   end

   assign tx_en        = tx_en_q;
   assign rx_en        = rx_en_q;
   assign core_reset_b = core_reset_b_q;
   assign link_up      = link_up_q;
   assign link_fail    = link_fail_q;
   assign state        = state_q;
   assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_jesd204b_link_seq.sv
// Directed bench for jesd204b_link_seq with small parameters and a state/output scoreboard.
// Covers bring-up, lock filter, timeouts, loss of sync, boundary sync and aborts.
module tb_jesd204b_link_seq;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WLCK = 3'd1;
   localparam logic [2:0] S_RST  = 3'd2;
   localparam logic [2:0] S_WSYN = 3'd3;
   localparam logic [2:0] S_UP   = 3'd4;
   localparam logic [2:0] S_FAIL = 3'd5;

   logic       clk = 1'b0;
   logic       reset_b, start, pll_lock, tx_sync_n, rx_sync_n;
   logic       tx_en, rx_en, core_reset_b, link_up, link_fail;
   logic [2:0] state;
   logic [3:0] retry_cnt;

   typedef struct {
      logic [2:0] st;
      logic [3:0] rc;
      logic [4:0] outs;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_rc = 0;
   int   n;

   jesd204b_link_seq #(
      .LOCK_FILT(4),
      .RST_CYCLES(8),
      .SYNC_TIMEOUT(64),
      .MAX_RETRY(2)
   ) dut (
      .link_clk(clk),
      .reset_b(reset_b),
      .start(start),
      .pll_lock(pll_lock),
      .tx_sync_n(tx_sync_n),
      .rx_sync_n(rx_sync_n),
      .tx_en(tx_en),
      .rx_en(rx_en),
      .core_reset_b(core_reset_b),
      .link_up(link_up),
      .link_fail(link_fail),
      .state(state),
      .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // outs = {tx_en, rx_en, core_reset_b, link_up, link_fail}
   task automatic push(input logic [2:0] st, input int rc);
      exp_t e;
      e.st = st;
      e.rc = 4'(rc);
      case (st)
         S_RST:   e.outs = 5'b11000;
         S_WSYN:  e.outs = 5'b11100;
         S_UP:    e.outs = 5'b11110;
         S_FAIL:  e.outs = 5'b00001;
         default: e.outs = 5'b00000;
      endcase
      sbq.push_back(e);
   endtask

   task automatic chk(input string tag);
      exp_t e;
      logic [11:0] got, want;
      e = sbq.pop_front();
      got  = {state, retry_cnt, tx_en, rx_en, core_reset_b, link_up, link_fail};
      want = {e.st, e.rc, e.outs};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed st/rc/outs=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic expect_now(input string tag, input logic [2:0] st, input int rc);
      push(st, rc);
      chk(tag);
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
      int k;
      k = 0;
      while (state !== st && k < budget) begin
         tick();
         k++;
      end
      checks++;
      assert (state === st) else begin
         errors++;
         $error("FAIL %s: observed state=%0d expected=%0d within %0d cycles",
                tag, state, st, budget);
      end
   endtask

   initial begin
      reset_b   = 1'b0;
      start     = 1'b0;
      pll_lock  = 1'b0;
      tx_sync_n = 1'b0;
      rx_sync_n = 1'b0;
      repeat (3) tick();
      expect_now("reset", S_IDLE, 0);
      reset_b = 1'b1;
      tick();
      expect_now("idle_no_start", S_IDLE, 0);

      // nominal bring-up
      start    = 1'b1;
      pll_lock = 1'b1;
      wait_state("reach_reset", S_RST, 20);
      n = 1;
      tick();
      while (state === S_RST && core_reset_b === 1'b0 && n < 40) begin
         n++;
         tick();
      end
      check_int("core_reset_low_cycles", n, 8);
      expect_now("enter_wait_sync", S_WSYN, 0);
      repeat (10) tick();
      tx_sync_n = 1'b1;
      rx_sync_n = 1'b1;
      tick();
      tick();
      expect_now("sync_latency_hold", S_WSYN, 0);
      tick();
      expect_now("nominal_up", S_UP, 0);

      // one-cycle rx loss of sync
      rx_sync_n = 1'b0;
      tick();
      rx_sync_n = 1'b1;
`ifdef JESD_SEQ_LOSS_DEBOUNCE_EN
      repeat (8) tick();
      expect_now("glitch_ignored", S_UP, 0);
      rx_sync_n = 1'b0;
      repeat (3) tick();
      rx_sync_n = 1'b1;
      repeat (6) tick();
      expect_now("three_low_ignored", S_UP, 0);
`else
      wait_state("glitch_to_reset", S_RST, 6);
      exp_rc = 1;
      expect_now("glitch_retry", S_RST, exp_rc);
      wait_state("glitch_reup", S_UP, 40);
      expect_now("glitch_reup_rc", S_UP, exp_rc);
`endif

      // four-cycle loss of sync
      rx_sync_n = 1'b0;
      repeat (4) tick();
      rx_sync_n = 1'b1;
      wait_state("loss4_to_reset", S_RST, 8);
      exp_rc++;
      expect_now("loss4_retry", S_RST, exp_rc);
      wait_state("loss4_reup", S_UP, 40);
      expect_now("loss4_reup_rc", S_UP, exp_rc);

      // lock drop in UP, then glitchy lock in WAIT_LOCK
      pll_lock = 1'b0;
      wait_state("lock_drop", S_WLCK, 6);
      expect_now("lock_drop_rc", S_WLCK, exp_rc);
      begin
         int pat [9] = '{1, 1, 0, 1, 1, 1, 0, 1, 0};
         for (int i = 0; i < 9; i++) begin
            pll_lock = pat[i][0];
            tick();
         end
      end
      expect_now("lock_glitch_hold", S_WLCK, exp_rc);
      pll_lock = 1'b1;
      repeat (5) tick();
      expect_now("lock_filter_hold", S_WLCK, exp_rc);
      tick();
      expect_now("lock_filter_exit", S_RST, exp_rc);
      wait_state("lock_reup", S_UP, 40);
      expect_now("lock_reup_rc", S_UP, exp_rc);

      start = 1'b0;
      tick();
      expect_now("stop_from_up", S_IDLE, 0);

      // timeouts until FAIL
      tx_sync_n = 1'b0;
      rx_sync_n = 1'b0;
      start     = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wait_state("tmo_enter", S_WSYN, 40);
         n = 1;
         tick();
         while (state === S_WSYN && n < 100) begin
            n++;
            tick();
         end
         check_int("tmo_window", n, 64);
         if (w < 2) expect_now("tmo_retry", S_RST, w + 1);
         else expect_now("tmo_fail", S_FAIL, 2);
      end
      repeat (5) tick();
      expect_now("fail_held", S_FAIL, 2);
      start = 1'b0;
      tick();
      expect_now("fail_to_idle", S_IDLE, 0);

      // sync lands on the last timeout cycle
      start = 1'b1;
      wait_state("bnd_enter", S_WSYN, 40);
      repeat (61) tick();
      tx_sync_n = 1'b1;
      rx_sync_n = 1'b1;
      tick();
      tick();
      expect_now("bnd_hold", S_WSYN, 0);
      tick();
      expect_now("bnd_sync_wins", S_UP, 0);

      // abort during RESET
      tx_sync_n = 1'b0;
      wait_state("abort_reach_reset", S_RST, 10);
      expect_now("abort_rc", S_RST, 1);
      start = 1'b0;
      tick();
      expect_now("abort_idle", S_IDLE, 0);

      // async reset mid-UP
      tx_sync_n = 1'b1;
      start     = 1'b1;
      wait_state("areset_up", S_UP, 60);
      expect_now("areset_up_rc", S_UP, 0);
      reset_b = 1'b0;
      #2;
      expect_now("areset_immediate", S_IDLE, 0);
      tick();
      expect_now("areset_held", S_IDLE, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
